// File: rtl/dmem_pkg.sv
// Shared types, funct3 encodings and access-legality helper for the data-memory controller.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // High when the size encoding is illegal for the direction or the address is misaligned for it.
    function automatic logic size_fault(input logic [2:0] funct3,
                                        input logic [1:0] addr_lo,
                                        input logic       is_store);
        logic f;
        f = 1'b1;
        case (funct3)
            F3_B:    f = 1'b0;
            F3_H:    f = addr_lo[0];
            F3_W:    f = (addr_lo != 2'b00);
            F3_BU:   f = is_store;
            F3_HU:   f = is_store | addr_lo[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store strobes/replicated data and right-alignment of the returned load word.
module dmem_lane_align (
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    input  logic [1:0]  load_off,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_aligned
);

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (size)
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    assign load_aligned = load_word >> {load_off, 3'b000};

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory controller: issues req/ack bus transactions, stalls the pipe while
// outstanding, and returns a right-aligned load word to the load-select stage.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadData,
    output logic        StallM,
    output logic        FaultM,
    output logic        BusErrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       rd_off;
    logic             req_any, fault, access_valid;
    logic             issue, finish_ack, finish_to;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata, rdata_aligned;

    assign req_any      = MemReadM | MemWriteM;
    assign fault        = req_any & size_fault(funct3M, ALUResultM[1:0], MemWriteM);
    assign access_valid = req_any & ~fault;
    assign FaultM       = (state == IDLE) & fault;
    assign StallM       = ((state == IDLE) & access_valid) | (state == BUSY);

    dmem_lane_align u_align (
        .size         (funct3M[1:0]),
        .addr_lo      (ALUResultM[1:0]),
        .store_data   (WriteDataM),
        .load_word    (mem_rdata),
        .load_off     (rd_off),
        .be           (lane_be),
        .wdata        (lane_wdata),
        .load_aligned (rdata_aligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Ack is checked before the timeout so a same-cycle ack completes normally.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        finish_ack = 1'b0;
        finish_to  = 1'b0;
        case (state)
            IDLE: begin
                if (access_valid) begin
                    issue      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    finish_ack = 1'b1;
                    state_next = DONE;
                end else if (TO_EN && (cnt == TO_LAST)) begin
                    finish_to  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            rd_off    <= '0;
            ReadData  <= '0;
            BusErrM   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            BusErrM <= 1'b0;
            if (issue) begin
                cnt       <= '0;
                rd_off    <= ALUResultM[1:0];
                mem_req   <= 1'b1;
                mem_we    <= MemWriteM;
                mem_addr  <= {ALUResultM[31:2], 2'b00};
                mem_wdata <= lane_wdata;
                mem_be    <= lane_be;
            end else if (state == BUSY) begin
                cnt <= cnt + CNT_W'(1);
                if (finish_ack || finish_to) begin
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    mem_be    <= '0;
                end
                if (finish_ack && !mem_we) ReadData <= rdata_aligned;
                if (finish_to) begin
                    BusErrM <= 1'b1;
                    if (!mem_we) ReadData <= '0;
                end
            end
        end
    end

endmodule
